pc_unit: RTL and testbench
==========================

// Module: pc_unit
// PURPOSE
//  Parametrised program-counter unit: holds the fetch PC and computes next PC from
//  sequential, branch, jump, call and return requests, with a small circular
//  return-address stack (RAS). Sits at the head of fetch and feeds imem address.
//  Generalises the plain enabled PC register with width, reset vector, step and modes.
// PARAMETERS
//  WIDTH      32  PC / address width in bits
//  RESET_PC   0   PC value loaded on reset (WIDTH bits)
//  STEP       1   sequential increment (1 = word-addressed imem)
//  RAS_DEPTH  4   return-stack entries; power of 2, >= 2
// PORTS
//  clk           in   1      single clock; all state updates on posedge
//  reset         in   1      synchronous, active-high
//  enable        in   1      1 = PC and RAS may update; 0 = hold everything (stall)
//  jump          in   1      absolute redirect request
//  jump_target   in   WIDTH  absolute target for jump
//  call          in   1      call: go to call_target, push pc+STEP
//  call_target   in   WIDTH  absolute call target
//  ret           in   1      return: pop RAS, go to popped address
//  br_taken      in   1      taken relative branch
//  br_offset     in   WIDTH  signed offset; target = pc + STEP + br_offset
//  pc            out  WIDTH  current PC (registered)
//  pc_plus       out  WIDTH  pc + STEP (combinational from pc)
//  ras_empty     out  1      RAS holds 0 entries
//  ras_full      out  1      RAS holds RAS_DEPTH entries
//  ras_overflow  out  1      sticky: a push occurred while full; cleared only by reset
//  ras_underflow out  1      registered 1-cycle pulse: ret issued while RAS empty
// BEHAVIOUR
//  - Reset (sync, highest priority): pc=RESET_PC, RAS count=0, ptr=0, ras_empty=1,
//    ras_full=0, ras_overflow=0, ras_underflow=0. RAS entry contents don't-care.
//  - enable=0: pc, RAS, flags hold; ras_underflow drops to 0; all requests ignored.
//  - enable=1, one-hot priority when several requests are high:
//    jump > ret > call > br_taken > sequential. Only the winner takes effect;
//    losers cause no RAS change and no flag change.
//  - sequential: pc <= pc+STEP. br_taken: pc <= pc+STEP+br_offset.
//    jump: pc <= jump_target. call: pc <= call_target, push pc+STEP.
//  - ret, RAS non-empty: pc <= top entry, pop (ptr-1, count-1).
//  - ret, RAS empty: pc <= pc+STEP, RAS unchanged, ras_underflow=1 next cycle only.
//  - push while full: overwrite oldest (circular write at ptr, ptr+1), count stays
//    RAS_DEPTH, ras_overflow set and held.
//  - All arithmetic modulo 2^WIDTH; wrap-around silent (0xFFFFFFFF+1 = 0).
//  - Latency: request sampled at posedge N is reflected on pc after posedge N; pc_plus
//    follows pc combinationally. No handshake; requests are level, one cycle each.
//  - ptr/count widths: ptr $clog2(RAS_DEPTH) bits (wraps naturally), count one wider.
//  - Reset asserted mid-sequence discards any pending request that same cycle.
// STRUCTURE
//  - Shared package pc_pkg: next-PC select enum (SEL_SEQ, SEL_BR, SEL_JUMP, SEL_CALL,
//    SEL_RET) and RAS_DEPTH/WIDTH defaults.
//  - One sub-module: return_stack (circular LIFO with push/pop/empty/full/overflow),
//    parametrised by WIDTH and RAS_DEPTH. Top level holds the pc register, priority
//    encoder and adders.
// TESTING
//  1 reset, RESET_PC=0x100, 3 cycles enable=1 -> pc 0x100,0x101,0x102,0x103; pc_plus=pc+1.
//  2 br_taken, br_offset=-2 at pc=0x10 -> pc=0x0F; enable=0 same cycle -> pc holds 0x10.
//  3 call 0x40 at pc=0x10, call 0x80 at 0x40, ret, ret -> pc 0x40,0x80,0x41,0x11;
//    ras_empty=1 at end.
//  4 five calls with RAS_DEPTH=4 -> ras_full=1, ras_overflow=1 sticky; four rets return
//    last four pushed addresses (oldest lost).
//  5 ret on empty at pc=0x20 -> pc=0x21, ras_underflow=1 for exactly one cycle.
//  6 jump,ret,call,br_taken all high -> jump wins, RAS count unchanged; pc=0xFFFFFFFF
//    sequential -> pc=0; reset mid-call -> pc=RESET_PC, RAS empty.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: next-PC select encoding
// and default geometry.
package pc_pkg;

    localparam int unsigned PC_WIDTH_DEFAULT  = 32;
    localparam int unsigned RAS_DEPTH_DEFAULT = 4;

    // Source of the next fetch PC, chosen by the request priority encoder.
    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_BR,
        SEL_JUMP,
        SEL_CALL,
        SEL_RET
    } next_sel_t;

endpackage : pc_pkg

// File: rtl/return_stack.sv
// Circular return-address stack. A push while full overwrites the oldest
// entry and sets a sticky overflow flag. A pop while empty is ignored.
module return_stack
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH     = PC_WIDTH_DEFAULT,
    parameter int unsigned RAS_DEPTH = RAS_DEPTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full,
    output logic             overflow
);

    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(RAS_DEPTH);

    logic [WIDTH-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]    ptr;
    logic [PW:0]      count;

    assign empty = (count == '0);
    assign full  = (count == FULL_COUNT);
    assign top   = mem[ptr - 1'b1];

    // Pointer, occupancy and overflow bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr      <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (push) begin
            ptr <= ptr + 1'b1;
            if (full) begin
                overflow <= 1'b1;
            end else begin
                count <= count + 1'b1;
            end
        end else if (pop && !empty) begin
            ptr   <= ptr - 1'b1;
            count <= count - 1'b1;
        end
    end

    // Entry storage; contents need no reset since count gates their use.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[ptr] <= push_data;
        end
    end

endmodule : return_stack

// File: rtl/pc_unit.sv
// Program-counter unit: fetch PC register, request priority encoder,
// next-PC adders and the return-address stack.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned       WIDTH     = PC_WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0]  RESET_PC  = '0,
    parameter int unsigned       STEP      = 1,
    parameter int unsigned       RAS_DEPTH = RAS_DEPTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             call,
    input  logic [WIDTH-1:0] call_target,
    input  logic             ret,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_offset,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_overflow,
    output logic             ras_underflow
);

    next_sel_t        sel;
    logic [WIDTH-1:0] next_pc;
    logic [WIDTH-1:0] ras_top;
    logic             ras_push;
    logic             ras_pop;
    logic             underflow_req;

    assign pc_plus = pc + WIDTH'(STEP);

    // Priority encoder: jump > ret > call > br_taken > sequential.
    // A ret on an empty stack still wins priority but falls back to sequential.
    always_comb begin
        sel           = SEL_SEQ;
        underflow_req = 1'b0;
        if (jump) begin
            sel = SEL_JUMP;
        end else if (ret) begin
            if (ras_empty) begin
                underflow_req = 1'b1;
            end else begin
                sel = SEL_RET;
            end
        end else if (call) begin
            sel = SEL_CALL;
        end else if (br_taken) begin
            sel = SEL_BR;
        end
    end

    // Next-PC mux over the selected source.
    always_comb begin
        next_pc = pc_plus;
        unique case (sel)
            SEL_SEQ:  next_pc = pc_plus;
            SEL_BR:   next_pc = pc_plus + br_offset;
            SEL_JUMP: next_pc = jump_target;
            SEL_CALL: next_pc = call_target;
            SEL_RET:  next_pc = ras_top;
            default:  next_pc = pc_plus;
        endcase
    end

    assign ras_push = enable && !reset && (sel == SEL_CALL);
    assign ras_pop  = enable && !reset && (sel == SEL_RET);

    // PC register: holds while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (enable) begin
            pc <= next_pc;
        end
    end

    // Underflow is a one-cycle pulse and drops during a stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            ras_underflow <= 1'b0;
        end else begin
            ras_underflow <= enable && underflow_req;
        end
    end

    return_stack #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_plus),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full),
        .overflow  (ras_overflow)
    );

endmodule : pc_unit

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus randomized
// traffic compared against a queue-based behavioural model.
module tb_pc_unit;

    localparam int unsigned W     = 32;
    localparam logic [W-1:0] RPC  = 32'h100;
    localparam int unsigned DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst, en, jmp, cl, rt, bt;
    logic [W-1:0] jt, ct, bo;
    logic [W-1:0] pc, pc_plus;
    logic         ras_empty, ras_full, ras_overflow, ras_underflow;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [W-1:0] m_pc;
    logic [W-1:0] m_q[$];
    logic         m_ovf, m_unf;

    always #5 clk = ~clk;

    pc_unit #(
        .WIDTH     (W),
        .RESET_PC  (RPC),
        .STEP      (1),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (rst),
        .enable        (en),
        .jump          (jmp),
        .jump_target   (jt),
        .call          (cl),
        .call_target   (ct),
        .ret           (rt),
        .br_taken      (bt),
        .br_offset     (bo),
        .pc            (pc),
        .pc_plus       (pc_plus),
        .ras_empty     (ras_empty),
        .ras_full      (ras_full),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    // Apply one cycle of inputs, advance the model, and sample #1 after the edge.
    task automatic step(input logic r, input logic e, input logic j, input logic [W-1:0] jtv,
                        input logic c, input logic [W-1:0] ctv, input logic re,
                        input logic b, input logic [W-1:0] bov);
        rst = r; en = e; jmp = j; jt = jtv; cl = c; ct = ctv; rt = re; bt = b; bo = bov;
        if (r) begin
            m_pc = RPC; m_q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        end else if (!e) begin
            m_unf = 1'b0;
        end else begin
            m_unf = 1'b0;
            if (j) m_pc = jtv;
            else if (re) begin
                if (m_q.size() > 0) m_pc = m_q.pop_back();
                else begin m_pc = m_pc + 1; m_unf = 1'b1; end
            end else if (c) begin
                m_q.push_back(m_pc + 1);
                if (m_q.size() > DEPTH) begin void'(m_q.pop_front()); m_ovf = 1'b1; end
                m_pc = ctv;
            end else if (b) m_pc = m_pc + 1 + bov;
            else m_pc = m_pc + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic seq();
        step(0, 1, 0, '0, 0, '0, 0, 0, '0);
    endtask

    task automatic do_jump(input logic [W-1:0] t);
        step(0, 1, 1, t, 0, '0, 0, 0, '0);
    endtask

    task automatic do_call(input logic [W-1:0] t);
        step(0, 1, 0, '0, 1, t, 0, 0, '0);
    endtask

    task automatic do_ret();
        step(0, 1, 0, '0, 0, '0, 1, 0, '0);
    endtask

    task automatic test_reset();
        logic [W-1:0] exp_pc;
        step(1, 0, 0, '0, 0, '0, 0, 0, '0);
        total++; if (pc !== 32'h100) begin $display("FAIL reset_pc got=%h exp=%h", pc, 32'h100); bad++; end
        total++; if ({ras_empty, ras_full, ras_overflow, ras_underflow} !== 4'b1000) begin
            $display("FAIL reset_flags got=%b exp=1000", {ras_empty, ras_full, ras_overflow, ras_underflow}); bad++; end
        exp_pc = 32'h100;
        for (int i = 0; i < 3; i++) begin
            seq();
            exp_pc = exp_pc + 1;
            total++; if (pc !== exp_pc) begin $display("FAIL seq_pc got=%h exp=%h", pc, exp_pc); bad++; end
            total++; if (pc_plus !== exp_pc + 1) begin $display("FAIL seq_pc_plus got=%h exp=%h", pc_plus, exp_pc + 1); bad++; end
        end
    endtask

    task automatic test_branch();
        do_jump(32'h10);
        step(0, 0, 0, '0, 0, '0, 0, 1, 32'hFFFF_FFFE);
        total++; if (pc !== 32'h10) begin $display("FAIL stall_hold got=%h exp=%h", pc, 32'h10); bad++; end
        step(0, 1, 0, '0, 0, '0, 0, 1, 32'hFFFF_FFFE);
        total++; if (pc !== 32'h0F) begin $display("FAIL branch_neg got=%h exp=%h", pc, 32'h0F); bad++; end
    endtask

    task automatic test_call_ret();
        logic [W-1:0] exp_seq [4];
        exp_seq = '{32'h40, 32'h80, 32'h41, 32'h11};
        do_jump(32'h10);
        do_call(32'h40);
        total++; if (pc !== exp_seq[0]) begin $display("FAIL call1 got=%h exp=%h", pc, exp_seq[0]); bad++; end
        do_call(32'h80);
        total++; if (pc !== exp_seq[1]) begin $display("FAIL call2 got=%h exp=%h", pc, exp_seq[1]); bad++; end
        do_ret();
        total++; if (pc !== exp_seq[2]) begin $display("FAIL ret1 got=%h exp=%h", pc, exp_seq[2]); bad++; end
        do_ret();
        total++; if (pc !== exp_seq[3]) begin $display("FAIL ret2 got=%h exp=%h", pc, exp_seq[3]); bad++; end
        total++; if (ras_empty !== 1'b1) begin $display("FAIL call_ret_empty got=%b exp=1", ras_empty); bad++; end
    endtask

    task automatic test_overflow();
        logic [W-1:0] exp_ret;
        step(1, 0, 0, '0, 0, '0, 0, 0, '0);
        for (int i = 0; i < 5; i++) do_call(32'h1000 + 32'(i) * 32'h10);
        total++; if (ras_full !== 1'b1) begin $display("FAIL ovf_full got=%b exp=1", ras_full); bad++; end
        total++; if (ras_overflow !== 1'b1) begin $display("FAIL ovf_flag got=%b exp=1", ras_overflow); bad++; end
        // Pushes were 0x101, 0x1001, 0x1011, 0x1021, 0x1031; the oldest is lost.
        for (int i = 0; i < 4; i++) begin
            exp_ret = 32'h1031 - 32'(i) * 32'h10;
            do_ret();
            total++; if (pc !== exp_ret) begin $display("FAIL ovf_ret%0d got=%h exp=%h", i, pc, exp_ret); bad++; end
        end
        total++; if ({ras_empty, ras_overflow} !== 2'b11) begin
            $display("FAIL ovf_sticky got=%b exp=11", {ras_empty, ras_overflow}); bad++; end
    endtask

    task automatic test_underflow();
        step(1, 0, 0, '0, 0, '0, 0, 0, '0);
        do_jump(32'h20);
        do_ret();
        total++; if (pc !== 32'h21) begin $display("FAIL unf_pc got=%h exp=%h", pc, 32'h21); bad++; end
        total++; if (ras_underflow !== 1'b1) begin $display("FAIL unf_pulse got=%b exp=1", ras_underflow); bad++; end
        seq();
        total++; if (ras_underflow !== 1'b0) begin $display("FAIL unf_drop got=%b exp=0", ras_underflow); bad++; end
    endtask

    task automatic test_priority();
        step(1, 0, 0, '0, 0, '0, 0, 0, '0);
        do_call(32'h200);
        step(0, 1, 1, 32'h300, 1, 32'h400, 1, 1, 32'h5);
        total++; if (pc !== 32'h300) begin $display("FAIL prio_pc got=%h exp=%h", pc, 32'h300); bad++; end
        total++; if (ras_empty !== 1'b0) begin $display("FAIL prio_ras got=%b exp=0", ras_empty); bad++; end
        do_ret();
        total++; if (pc !== 32'h101) begin $display("FAIL prio_ret got=%h exp=%h", pc, 32'h101); bad++; end
        do_jump(32'hFFFF_FFFF);
        seq();
        total++; if (pc !== 32'h0) begin $display("FAIL wrap got=%h exp=0", pc); bad++; end
        do_call(32'h500);
        step(1, 1, 0, '0, 1, 32'h600, 0, 0, '0);
        total++; if (pc !== RPC) begin $display("FAIL rst_mid_call got=%h exp=%h", pc, RPC); bad++; end
        total++; if (ras_empty !== 1'b1) begin $display("FAIL rst_mid_empty got=%b exp=1", ras_empty); bad++; end
    endtask

    task automatic test_random();
        logic r, e, j, c, re, b;
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 49) == 0);
            e  = ($urandom_range(0, 5) != 0);
            j  = ($urandom_range(0, 7) == 0);
            c  = ($urandom_range(0, 3) == 0);
            re = ($urandom_range(0, 3) == 0);
            b  = ($urandom_range(0, 4) == 0);
            step(r, e, j, $urandom, c, $urandom, re, b, W'($signed($urandom_range(0, 64)) - 32));
            total++; if (pc !== m_pc) begin $display("FAIL rnd_pc cyc=%0d got=%h exp=%h", i, pc, m_pc); bad++; end
            total++; if (pc_plus !== m_pc + 1) begin $display("FAIL rnd_pc_plus cyc=%0d got=%h exp=%h", i, pc_plus, m_pc + 1); bad++; end
            total++; if ({ras_empty, ras_full, ras_overflow, ras_underflow} !==
                         {m_q.size() == 0, m_q.size() == DEPTH, m_ovf, m_unf}) begin
                $display("FAIL rnd_flags cyc=%0d got=%b exp=%b", i, {ras_empty, ras_full, ras_overflow, ras_underflow},
                         {m_q.size() == 0, m_q.size() == DEPTH, m_ovf, m_unf});
                bad++;
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; jmp = 1'b0; cl = 1'b0; rt = 1'b0; bt = 1'b0;
        jt = '0; ct = '0; bo = '0;
        m_pc = RPC; m_ovf = 1'b0; m_unf = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_branch();
        test_call_ret();
        test_overflow();
        test_underflow();
        test_priority();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pc_unit
